// File: rtl/vma_diag_reader.sv
// Diagnostic EBUS reader: walks DIAG[4:6] through all eight VMA readback selects and de-interleaves a snapshot.
// Latency: start at cycle T -> done at T+8*SETTLE_CYCLES+1; start while busy or in DONE is dropped (no queuing).
// Optional VMA_DIAG_CHECK_EN adds check_err, a consistency check of the match/zero flags against the captured fields.
module vma_diag_reader #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    output logic [2:0]   diag_sel,
    output logic         read_func,
    input  logic [0:35]  ebus_data,
    input  logic         ebus_driving,
    output logic         busy,
    output logic         done,
    output logic         drv_err,
    output logic [13:35] pc,
    output logic [13:35] held,
    output logic [13:35] adr_brk,
    output logic [13:35] vma,
    output logic [13:17] prev_sec,
    output logic         n_misc0,
    output logic         n_ac_ref,
    output logic         n_local_ac,
    output logic         n_match,
    output logic         n_vma_s0,
    output logic         n_pc_s0,
    output logic         n_pcs_s0
`ifdef VMA_DIAG_CHECK_EN
    ,
    output logic         check_err
`endif
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t         state;
    logic [CW-1:0]  cnt;

    logic [1:0]     j;
    logic [13:35]   base;
    logic [13:35]   msk;
    logic [13:35]   sp_a;
    logic [13:35]   sp_b;
    logic           unused_ebus;

    // Each field nibble g..g+3 takes bit j = 3 - (sel mod 4); bits 13..15 only exist for j<3.
    always_comb begin
        j    = ~diag_sel[1:0];
        base = (diag_sel[1:0] == 2'd0) ? 23'h088888 : 23'h488888;
        msk  = base >> j;
        sp_a = {ebus_data[13], 2'b0, ebus_data[17], 3'b0, ebus_data[21], 3'b0,
                ebus_data[25], 3'b0, ebus_data[29], 3'b0, ebus_data[33], 3'b0} >> j;
        sp_b = {ebus_data[15], 2'b0, ebus_data[19], 3'b0, ebus_data[23], 3'b0,
                ebus_data[27], 3'b0, ebus_data[31], 3'b0, ebus_data[35], 3'b0} >> j;
    end

    assign unused_ebus = ^{ebus_data[0:10], ebus_data[12], ebus_data[14], ebus_data[16],
                           ebus_data[18], ebus_data[20], ebus_data[22], ebus_data[24],
                           ebus_data[26], ebus_data[28], ebus_data[30], ebus_data[32],
                           ebus_data[34]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            diag_sel   <= '0;
            read_func  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            drv_err    <= 1'b0;
            pc         <= '0;
            held       <= '0;
            adr_brk    <= '0;
            vma        <= '0;
            prev_sec   <= '0;
            n_misc0    <= 1'b0;
            n_ac_ref   <= 1'b0;
            n_local_ac <= 1'b0;
            n_match    <= 1'b0;
            n_vma_s0   <= 1'b0;
            n_pc_s0    <= 1'b0;
            n_pcs_s0   <= 1'b0;
`ifdef VMA_DIAG_CHECK_EN
            check_err  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= SCAN;
                        diag_sel  <= '0;
                        cnt       <= RELOAD;
                        drv_err   <= 1'b0;
                        read_func <= 1'b1;
                        busy      <= 1'b1;
`ifdef VMA_DIAG_CHECK_EN
                        check_err <= 1'b0;
`endif
                    end
                end
                SCAN: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        if (diag_sel[2]) begin
                            pc      <= (pc & ~msk) | (sp_a & msk);
                            adr_brk <= (adr_brk & ~msk) | (sp_b & msk);
                        end else begin
                            held    <= (held & ~msk) | (sp_a & msk);
                            vma     <= (vma & ~msk) | (sp_b & msk);
                        end
                        case (diag_sel)
                            3'd7: n_vma_s0 <= ebus_data[11];
                            3'd6: n_pc_s0  <= ebus_data[11];
                            3'd5: n_pcs_s0 <= ebus_data[11];
                            3'd4: begin
                                n_misc0      <= ebus_data[13];
                                n_local_ac   <= ebus_data[15];
                                prev_sec[13] <= ebus_data[11];
                            end
                            3'd3: prev_sec[14] <= ebus_data[11];
                            3'd2: prev_sec[15] <= ebus_data[11];
                            3'd1: prev_sec[16] <= ebus_data[11];
                            default: begin
                                n_ac_ref     <= ebus_data[13];
                                n_match      <= ebus_data[15];
                                prev_sec[17] <= ebus_data[11];
                            end
                        endcase
                        if (!ebus_driving) drv_err <= 1'b1;
                        if (diag_sel == 3'd7) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            read_func <= 1'b0;
                            busy      <= 1'b0;
                        end else begin
                            diag_sel <= diag_sel + 3'd1;
                            cnt      <= RELOAD;
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    diag_sel <= '0;
`ifdef VMA_DIAG_CHECK_EN
                    check_err <= (n_match != (adr_brk != vma)) ||
                                 (n_vma_s0 != (vma[13:16] != 4'd0));
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vma_diag_reader.sv
// Bench for vma_diag_reader: a VMA mux model answers each select; a scoreboard compares every done snapshot.
module tb_vma_diag_reader;

    localparam int SETTLE = 2;
    localparam int LAT    = 8 * SETTLE + 1;

    typedef struct {
        logic [13:35] pc;
        logic [13:35] held;
        logic [13:35] adr_brk;
        logic [13:35] vma;
        logic [13:17] prev_sec;
        logic [6:0]   flg; // {misc0, ac_ref, local_ac, match, vma_s0, pc_s0, pcs_s0}
        logic         drv_err;
        int           done_cyc;
    } snap_t;

    logic         clk, reset_n, start;
    logic [2:0]   diag_sel;
    logic         read_func, ebus_driving, busy, done, drv_err;
    logic [0:35]  ebus_data;
    logic [13:35] pc, held, adr_brk, vma;
    logic [13:17] prev_sec;
    logic         n_misc0, n_ac_ref, n_local_ac, n_match, n_vma_s0, n_pc_s0, n_pcs_s0;
`ifdef VMA_DIAG_CHECK_EN
    logic         check_err;
    logic         ce_pend = 1'b0;
    logic         ce_exp;
`endif

    int     total = 0;
    int     bad   = 0;
    int     cyc   = 0;
    snap_t  exp_q[$];
    snap_t  cur;
    snap_t  mon_e;
    logic [0:35] garb;
    logic [0:35] used;
    logic        fault_en;
    logic [2:0]  fault_sel;

    vma_diag_reader #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .diag_sel(diag_sel),
        .read_func(read_func), .ebus_data(ebus_data), .ebus_driving(ebus_driving),
        .busy(busy), .done(done), .drv_err(drv_err),
        .pc(pc), .held(held), .adr_brk(adr_brk), .vma(vma), .prev_sec(prev_sec),
        .n_misc0(n_misc0), .n_ac_ref(n_ac_ref), .n_local_ac(n_local_ac),
        .n_match(n_match), .n_vma_s0(n_vma_s0), .n_pc_s0(n_pc_s0), .n_pcs_s0(n_pcs_s0)
`ifdef VMA_DIAG_CHECK_EN
        , .check_err(check_err)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // VMA board side: what each readback select puts on the odd EBUS bits.
    function automatic logic [0:35] mux(input logic [2:0] s, input snap_t m);
        logic [0:35] d;
        int si, g;
        d  = '0;
        si = int'(s);
        for (int k = 0; k < 5; k++) begin
            g = 16 + 4 * k;
            if (si >= 4) begin
                d[17 + 4 * k] = m.pc[g + 7 - si];
                d[19 + 4 * k] = m.adr_brk[g + 7 - si];
            end else begin
                d[17 + 4 * k] = m.held[g + 3 - si];
                d[19 + 4 * k] = m.vma[g + 3 - si];
            end
        end
        if (si >= 5) begin
            d[13] = m.pc[13 + 7 - si];
            d[15] = m.adr_brk[13 + 7 - si];
        end else if (si == 4) begin
            d[13] = m.flg[6];
            d[15] = m.flg[4];
        end else if (si >= 1) begin
            d[13] = m.held[13 + 3 - si];
            d[15] = m.vma[13 + 3 - si];
        end else begin
            d[13] = m.flg[5];
            d[15] = m.flg[3];
        end
        case (si)
            7:       d[11] = m.flg[2];
            6:       d[11] = m.flg[1];
            5:       d[11] = m.flg[0];
            default: d[11] = m.prev_sec[17 - si];
        endcase
        return d;
    endfunction

    always_comb begin
        ebus_data    = mux(diag_sel, cur) | (garb & ~used);
        ebus_driving = !(fault_en && read_func && (diag_sel == fault_sel));
    end

    function automatic snap_t make(input logic [22:0] p, input logic [22:0] h, input logic [22:0] a,
                                   input logic [22:0] v, input logic [4:0] ps, input logic [6:0] f);
        snap_t s;
        s.pc = p; s.held = h; s.adr_brk = a; s.vma = v; s.prev_sec = ps; s.flg = f;
        s.drv_err = 1'b0; s.done_cyc = 0;
        return s;
    endfunction

    function automatic snap_t rnd_snap();
        return make(23'($urandom), 23'($urandom), 23'($urandom), 23'($urandom),
                    5'($urandom), 7'($urandom));
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        if (reset_n) begin
`ifdef VMA_DIAG_CHECK_EN
            if (ce_pend) begin
                chk("check_err", check_err, ce_exp);
                ce_pend = 1'b0;
            end
`endif
            if (done) begin
                chk("done_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    chk("done_cycle", cyc, mon_e.done_cyc);
                    chk("pc", pc, mon_e.pc);
                    chk("held", held, mon_e.held);
                    chk("adr_brk", adr_brk, mon_e.adr_brk);
                    chk("vma", vma, mon_e.vma);
                    chk("prev_sec", prev_sec, mon_e.prev_sec);
                    chk("flags", {n_misc0, n_ac_ref, n_local_ac, n_match, n_vma_s0, n_pc_s0, n_pcs_s0},
                        mon_e.flg);
                    chk("drv_err", drv_err, mon_e.drv_err);
                    chk("done_busy", busy, 1'b0);
                    chk("done_read_func", read_func, 1'b0);
`ifdef VMA_DIAG_CHECK_EN
                    ce_exp  = (mon_e.flg[3] != (mon_e.adr_brk != mon_e.vma)) ||
                              (mon_e.flg[2] != (mon_e.vma[13:16] != 4'd0));
                    ce_pend = 1'b1;
`endif
                end
            end
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_read_func"}, read_func, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_drv_err"}, drv_err, 1'b0);
        chk({tag, "_diag_sel"}, diag_sel, 3'd0);
        chk({tag, "_fields"}, {pc, held, adr_brk, vma, prev_sec} == '0, 1'b1);
        chk({tag, "_flags"}, {n_misc0, n_ac_ref, n_local_ac, n_match, n_vma_s0, n_pc_s0, n_pcs_s0}, 7'd0);
    endtask

    task automatic run_scan(input snap_t s, input logic f_en, input logic [2:0] f_sel, input logic extra);
        int t;
        cur       = s;
        garb      = {$urandom, 4'($urandom)};
        fault_en  = f_en;
        fault_sel = f_sel;
        @(posedge clk);
        #1;
        start      = 1'b1;
        t          = cyc;
        s.drv_err  = f_en;
        s.done_cyc = t + LAT;
        exp_q.push_back(s);
        @(posedge clk);
        #1 start = 1'b0;
        wait_cyc(t + 2);
        chk("scan_busy", busy, 1'b1);
        chk("scan_read_func", read_func, 1'b1);
        chk("scan_sel0", diag_sel, 3'd0);
        wait_cyc(t + 4);
        chk("scan_sel1", diag_sel, 3'd1);
        if (extra) begin
            wait_cyc(t + 5);
            start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        wait_cyc(t + LAT + 3);
        chk("pending_after_scan", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        snap_t s;
        int t;
        for (int b = 0; b < 36; b++) used[b] = (b >= 11) && (b % 2 == 1);
        reset_n   = 1'b0;
        start     = 1'b0;
        garb      = '0;
        fault_en  = 1'b0;
        fault_sel = 3'd0;
        cur       = make(23'd0, 23'd0, 23'd0, 23'd0, 5'd0, 7'd0);
        #23;
        check_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // single marker bits
        s = make(23'd0, 23'd0, 23'd0, 23'd0, 5'd0, 7'd0);
        s.pc[16]  = 1'b1;
        s.vma[35] = 1'b1;
        run_scan(s, 1'b0, 3'd0, 1'b0);

        run_scan(make(23'h012345, 23'h7FFFFF, 23'h000000, 23'h000001, 5'h15, 7'b1010011),
                 1'b0, 3'd0, 1'b0);

        // driver dropout at select 3, then a clean scan clears it
        run_scan(rnd_snap(), 1'b1, 3'd3, 1'b0);
        run_scan(rnd_snap(), 1'b0, 3'd0, 1'b0);

        // second start mid-scan is ignored
        run_scan(rnd_snap(), 1'b0, 3'd0, 1'b1);

        for (int i = 0; i < 8; i++)
            run_scan(rnd_snap(), ($urandom % 3) == 0, 3'($urandom), ($urandom % 4) == 0);

`ifdef VMA_DIAG_CHECK_EN
        run_scan(make(23'd0, 23'd0, 23'h000100, 23'h000100, 5'd0, 7'b0001000), 1'b0, 3'd0, 1'b0);
        run_scan(make(23'd0, 23'd0, 23'h000100, 23'h000100, 5'd0, 7'b0000000), 1'b0, 3'd0, 1'b0);
`endif

        // reset in the middle of a scan
        cur      = make(23'h7FFFFF, 23'h7FFFFF, 23'h7FFFFF, 23'h7FFFFF, 5'h1F, 7'h7F);
        fault_en = 1'b1;
        fault_sel = 3'd0;
        @(posedge clk);
        #1 start = 1'b1;
        t = cyc;
        @(posedge clk);
        #1 start = 1'b0;
        wait_cyc(t + 9);
        chk("pre_reset_busy", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        check_zero("midreset");
        @(posedge clk);
        #1 reset_n = 1'b1;
        fault_en = 1'b0;
        wait_cyc(t + LAT + 8);
        chk("no_done_after_reset", exp_q.size(), 0);

        run_scan(rnd_snap(), 1'b0, 3'd0, 1'b0);

        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
